// File: rtl/fft_process.sv
// fft_process: single-shot 1024-point radix-2 DIT FFT spectrum analyser on Q1.15 ADC samples.
// Define FFT_HALF_SPECTRUM_EN to stream only bins 0..N_FFT/2-1 instead of the full spectrum.
module fft_process #(
    parameter int unsigned N_FFT         = 1024,
    parameter int unsigned TOTAL_SAMPLES = 1200,
    parameter int unsigned DISCARD_HEAD  = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [15:0]        adc_input,
    input  logic               adc_valid,
    output logic               ready_for_data,
    output logic [27:0]        magnitude,
    output logic signed [26:0] real_part,
    output logic signed [26:0] imag_part,
    output logic [9:0]         bin_index,
    output logic               magnitude_valid,
    output logic               processing_done
);

    localparam int unsigned LOG2N = $clog2(N_FFT);
    localparam int unsigned HALF  = N_FFT / 2;
    localparam int unsigned SCW   = $clog2(TOTAL_SAMPLES + 1);
    localparam int unsigned DW    = 27;
    localparam real         PI    = 3.14159265358979323846;

`ifdef FFT_HALF_SPECTRUM_EN
    localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(HALF - 1);
`else
    localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(N_FFT - 1);
`endif

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SAMPLING = 4'd1,
        COMPUTE  = 4'd6,
        OUTPUT   = 4'd7,
        DONE     = 4'd9
    } state_t;

    state_t state, state_next;

    logic signed [DW-1:0] mem_re [N_FFT];
    logic signed [DW-1:0] mem_im [N_FFT];

    logic [SCW-1:0]   sample_count;
    logic [LOG2N:0]   buffer_index;
    logic [3:0]       stage;
    logic [LOG2N-2:0] bfly;
    logic             phase;
    logic [LOG2N-1:0] out_bin;

    logic accept, store, sample_last, compute_last, output_last;

    logic [LOG2N-1:0] span_mask, bfly_ext, addr_a, addr_b;
    logic [LOG2N-2:0] tw_idx;

    logic signed [DW-1:0] op_a_re, op_a_im, op_b_re, op_b_im;
    logic signed [15:0]   tw_c, tw_s;
    logic                 tw_zero;

    logic signed [DW:0]   t_re, t_im, a_re_x, a_im_x;
    logic signed [DW-1:0] x_re, x_im, y_re, y_im;

    logic signed [15:0] cos_rom [HALF];
    logic signed [15:0] sin_rom [HALF];

    // W^k = cos - j*sin; sin is stored positive and subtracted in the butterfly
    for (genvar g = 0; g < HALF; g++) begin : g_tw
        localparam real ANG   = 2.0 * PI * real'(g) / real'(N_FFT);
        localparam int  COS_I = $rtoi($floor($cos(ANG) * 32768.0 + 0.5));
        localparam int  SIN_I = $rtoi($floor($sin(ANG) * 32768.0 + 0.5));
        assign cos_rom[g] = (COS_I > 32767) ? 16'sd32767 : 16'(COS_I);
        assign sin_rom[g] = (SIN_I > 32767) ? 16'sd32767 : 16'(SIN_I);
    end

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    function automatic logic signed [DW:0] rmul(input logic signed [DW-1:0] x,
                                                input logic signed [15:0]   w);
        logic signed [DW+15:0] p;
        p = (DW+16)'(x) * (DW+16)'(w);
        return (DW+1)'((p + (DW+16)'(16384)) >>> 15);
    endfunction

    function automatic logic [DW-1:0] absval(input logic signed [DW-1:0] v);
        return v[DW-1] ? DW'(-v) : v;
    endfunction

    assign accept       = adc_valid & ready_for_data;
    assign store        = accept && (sample_count >= SCW'(DISCARD_HEAD)) && !buffer_index[LOG2N];
    assign sample_last  = accept && (sample_count == SCW'(TOTAL_SAMPLES - 1));
    assign compute_last = phase && (stage == 4'(LOG2N - 1)) && (bfly == '1);
    assign output_last  = (out_bin == LAST_BIN);

    // Butterfly j of stage s pairs a = insert-zero-at-bit-s(j) with b = a + 2^s
    always_comb begin
        span_mask = (LOG2N'(1) << stage) - LOG2N'(1);
        bfly_ext  = {1'b0, bfly};
        addr_a    = ((bfly_ext & ~span_mask) << 1) | (bfly_ext & span_mask);
        addr_b    = addr_a | (span_mask + LOG2N'(1));
        tw_idx    = (bfly & span_mask[LOG2N-2:0]) << (4'(LOG2N - 1) - stage);
    end

    always_comb begin
        if (tw_zero) begin
            t_re = (DW+1)'(op_b_re);
            t_im = (DW+1)'(op_b_im);
        end else begin
            t_re = rmul(op_b_re, tw_c) + rmul(op_b_im, tw_s);
            t_im = rmul(op_b_im, tw_c) - rmul(op_b_re, tw_s);
        end
        a_re_x = (DW+1)'(op_a_re);
        a_im_x = (DW+1)'(op_a_im);
        x_re   = DW'(a_re_x + t_re);
        x_im   = DW'(a_im_x + t_im);
        y_re   = DW'(a_re_x - t_re);
        y_im   = DW'(a_im_x - t_im);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next      = state;
        ready_for_data  = (state == SAMPLING);
        processing_done = (state == DONE);
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:     state_next = SAMPLING;
                SAMPLING: if (sample_last)  state_next = COMPUTE;
                COMPUTE:  if (compute_last) state_next = OUTPUT;
                OUTPUT:   if (output_last)  state_next = DONE;
                DONE:     state_next = DONE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count    <= '0;
            buffer_index    <= '0;
            stage           <= '0;
            bfly            <= '0;
            phase           <= 1'b0;
            out_bin         <= '0;
            magnitude_valid <= 1'b0;
            magnitude       <= '0;
            real_part       <= '0;
            imag_part       <= '0;
            bin_index       <= '0;
        end else begin
            magnitude_valid <= 1'b0;
            if (!enable || state == IDLE) begin
                sample_count <= '0;
                buffer_index <= '0;
                stage        <= '0;
                bfly         <= '0;
                phase        <= 1'b0;
                out_bin      <= '0;
            end else begin
                if (accept) sample_count <= sample_count + SCW'(1);
                if (store)  buffer_index <= buffer_index + (LOG2N+1)'(1);
                if (state == COMPUTE) begin
                    phase <= ~phase;
                    if (phase) begin
                        bfly <= bfly + 1'b1;
                        if (bfly == '1) stage <= stage + 4'd1;
                    end
                end
                if (state == OUTPUT) begin
                    magnitude_valid <= 1'b1;
                    bin_index       <= out_bin;
                    real_part       <= mem_re[out_bin];
                    imag_part       <= mem_im[out_bin];
                    magnitude       <= {1'b0, absval(mem_re[out_bin])} + {1'b0, absval(mem_im[out_bin])};
                    out_bin         <= out_bin + 1'b1;
                end
            end
        end
    end

    // Operands are captured in phase 0 and the results written back in phase 1
    always_ff @(posedge clk) begin
        if (state == COMPUTE && !phase) begin
            op_a_re <= mem_re[addr_a];
            op_a_im <= mem_im[addr_a];
            op_b_re <= mem_re[addr_b];
            op_b_im <= mem_im[addr_b];
            tw_c    <= cos_rom[tw_idx];
            tw_s    <= sin_rom[tw_idx];
            tw_zero <= (tw_idx == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_re[bitrev(buffer_index[LOG2N-1:0])] <= DW'($signed(adc_input));
            mem_im[bitrev(buffer_index[LOG2N-1:0])] <= '0;
        end else if (state == COMPUTE && phase) begin
            mem_re[addr_a] <= x_re;
            mem_im[addr_a] <= x_im;
            mem_re[addr_b] <= y_re;
            mem_im[addr_b] <= y_im;
        end
    end

endmodule

// File: tb/tb_fft_process.sv
// tb_fft_process: directed self-checking bench for fft_process (full-spectrum build).
module tb_fft_process;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] adc_input;
    logic        adc_valid;
    logic        ready_for_data;
    logic [27:0] magnitude;
    logic [26:0] real_part;
    logic [26:0] imag_part;
    logic [9:0]  bin_index;
    logic        magnitude_valid;
    logic        processing_done;

    int n_cmp = 0;
    int n_bad = 0;

    fft_process dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .adc_input       (adc_input),
        .adc_valid       (adc_valid),
        .ready_for_data  (ready_for_data),
        .magnitude       (magnitude),
        .real_part       (real_part),
        .imag_part       (imag_part),
        .bin_index       (bin_index),
        .magnitude_valid (magnitude_valid),
        .processing_done (processing_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tri_sample(input int n);
        int ph, v;
        ph = (n * 60) % 500;
        if (ph < 250) v = -32767 + (ph * 65534) / 250;
        else          v =  32767 - ((ph - 250) * 65534) / 250;
        return 16'(v);
    endfunction

    // kind: 0 constant 0x4000, 1 impulse at sample 100, 2 triangle (valid every 2nd clk)
    function automatic logic [15:0] sample_of(input int kind, input int n);
        if (kind == 0) return 16'h4000;
        if (kind == 1) return (n == 100) ? 16'h7FFF : 16'h0000;
        return tri_sample(n);
    endfunction

    task automatic run_samples(input int kind, input bit stall);
        int idx = 0;
        int guard = 0;
        int gap = 0;
        while (idx < 1200 && guard < 6000) begin
            @(negedge clk);
            guard++;
            if (stall && idx == 600 && gap < 50) begin
                adc_valid = 1'b0;
                gap++;
                if (gap == 50) chk("stall_ready_held", 32'(ready_for_data), 32'd1);
            end else if (kind == 2 && (guard % 2) == 1) begin
                adc_valid = 1'b0;
            end else if (ready_for_data) begin
                adc_input = sample_of(kind, idx);
                adc_valid = 1'b1;
                idx++;
            end else begin
                adc_valid = 1'b0;
            end
        end
        chk("samples_fed", 32'(idx), 32'd1200);
        @(negedge clk);
        chk("ready_drop_after_1200", 32'(ready_for_data), 32'd0);
        chk("state_compute", 32'(dut.state), 32'd6);
        adc_valid = 1'b1;
        adc_input = 16'h7FFF;
    endtask

    task automatic collect(input int kind);
        int guard = 0;
        int pulses = 0;
        int max1 = -1, idx1 = -1, max2 = -1, idx2 = -1;
        while (!magnitude_valid && guard < 13000) begin
            @(negedge clk);
            guard++;
        end
        chk("first_valid_seen", 32'(magnitude_valid), 32'd1);
        while (magnitude_valid && pulses < 1100) begin
            chk($sformatf("bin_index[%0d]", pulses), 32'(bin_index), 32'(pulses));
            if (kind == 0) begin
                chk($sformatf("c_re[%0d]", pulses), 32'(real_part), (pulses == 0) ? 32'h100_0000 : 32'd0);
                chk($sformatf("c_im[%0d]", pulses), 32'(imag_part), 32'd0);
                chk($sformatf("c_mag[%0d]", pulses), 32'(magnitude), (pulses == 0) ? 32'h100_0000 : 32'd0);
            end else if (kind == 1) begin
                chk($sformatf("i_re[%0d]", pulses), 32'(real_part), 32'd32767);
                chk($sformatf("i_im[%0d]", pulses), 32'(imag_part), 32'd0);
                chk($sformatf("i_mag[%0d]", pulses), 32'(magnitude), 32'd32767);
            end else begin
                if (pulses >= 1 && pulses < 512 && int'(magnitude) > max1) begin
                    max1 = int'(magnitude);
                    idx1 = pulses;
                end
                if (pulses >= 512 && int'(magnitude) > max2) begin
                    max2 = int'(magnitude);
                    idx2 = pulses;
                end
            end
            pulses++;
            @(negedge clk);
        end
        chk("valid_pulse_count", 32'(pulses), 32'd1024);
        chk("bin_index_held", 32'(bin_index), 32'd1023);
        if (kind == 1) chk("real_part_held", 32'(real_part), 32'd32767);
        if (kind == 2) begin
            chk("tri_peak_low_half", 32'(idx1), 32'd123);
            chk("tri_peak_mirror", 32'(idx2), 32'd901);
        end
        chk("done_level", 32'(processing_done), 32'd1);
        chk("ready_low_in_done", 32'(ready_for_data), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_held", 32'(processing_done), 32'd1);
    endtask

    task automatic end_run();
        enable    = 1'b0;
        adc_valid = 1'b1;
        adc_input = 16'h5555;
        @(negedge clk);
        chk("idle_after_enable_low", 32'(dut.state), 32'd0);
        chk("done_cleared", 32'(processing_done), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int stray;
        rst       = 1'b1;
        enable    = 1'b0;
        adc_valid = 1'b0;
        adc_input = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dut.state), 32'd0);
        chk("rst_ready", 32'(ready_for_data), 32'd0);
        chk("rst_mag", 32'(magnitude), 32'd0);
        chk("rst_re", 32'(real_part), 32'd0);
        chk("rst_im", 32'(imag_part), 32'd0);
        chk("rst_bin", 32'(bin_index), 32'd0);
        chk("rst_valid", 32'(magnitude_valid), 32'd0);
        chk("rst_done", 32'(processing_done), 32'd0);
        rst       = 1'b0;
        adc_valid = 1'b1;
        adc_input = 16'h1234;
        repeat (2) @(negedge clk);
        chk("idle_ignores_valid", 32'(ready_for_data), 32'd0);

        // constant input
        enable = 1'b1;
        run_samples(0, 1'b0);
        collect(0);
        end_run();

        // impulse
        enable = 1'b1;
        run_samples(1, 1'b0);
        collect(1);
        end_run();

        // constant input with a 50-cycle ADC stall mid-sampling
        enable = 1'b1;
        run_samples(0, 1'b1);
        collect(0);
        end_run();

        // triangle, 60 kHz at 500 kS/s
        enable = 1'b1;
        run_samples(2, 1'b0);
        collect(2);
        end_run();

        // reset pulse during sampling
        enable = 1'b1;
        repeat (300) begin
            @(negedge clk);
            adc_valid = 1'b1;
            adc_input = 16'h2222;
        end
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("midrst_state", 32'(dut.state), 32'd0);
        chk("midrst_ready", 32'(ready_for_data), 32'd0);
        chk("midrst_bin", 32'(bin_index), 32'd0);
        chk("midrst_re", 32'(real_part), 32'd0);
        chk("midrst_mag", 32'(magnitude), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // abort during compute, then rerun
        enable = 1'b1;
        run_samples(1, 1'b0);
        repeat (2000) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_state_idle", 32'(dut.state), 32'd0);
        chk("abort_ready", 32'(ready_for_data), 32'd0);
        stray = 0;
        repeat (200) begin
            @(negedge clk);
            if (magnitude_valid) stray++;
        end
        chk("abort_no_valid", 32'(stray), 32'd0);
        chk("abort_done_low", 32'(processing_done), 32'd0);
        enable = 1'b1;
        run_samples(1, 1'b0);
        collect(1);
        end_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
